gf_alu_pipe: RTL and testbench

//  Multi-lane pipelined GF(2^SYMB_WIDTH) arithmetic unit: per lane MULT, DIV, INV or POW on symbols.

---
 rtl/gf_pkg.sv | 31 +++
 rtl/gf_alu_lane.sv | 159 +++++++++++++++
 rtl/gf_alu_pipe.sv | 71 +++++++
 tb/tb_gf_alu_pipe.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^m) types, op encoding and elaboration-time helpers for the
// field arithmetic pipeline.
package gf_pkg;

  localparam int GF_SYMB_WIDTH = 8;
  localparam int GF_POLY       = 285;
  localparam int FIELD_CHARAC  = (1 << GF_SYMB_WIDTH) - 1;

  typedef logic [GF_SYMB_WIDTH-1:0] symb_t;   // field element
  typedef logic [GF_SYMB_WIDTH-1:0] alpha_t;  // exponent of alpha

  typedef enum logic [1:0] {
    GF_MULT = 2'd0,
    GF_DIV  = 2'd1,
    GF_INV  = 2'd2,
    GF_POW  = 2'd3
  } gf_op_e;

  function automatic int gf_field_charac(input int m);
    return (1 << m) - 1;
  endfunction

  // One LFSR step: multiply x by alpha modulo the primitive polynomial.
  function automatic int gf_lfsr_step(input int x, input int m, input int poly);
    int y;
    y = x << 1;
    if (((y >> m) & 1) != 0) y = y ^ poly;
    return y;
  endfunction

endpackage

// File: rtl/gf_alu_lane.sv
// One lane of the 3-stage field ALU: log lookup, exponent arithmetic
// modulo 2^m-1, antilog lookup with zero/error masking.
module gf_alu_lane
  import gf_pkg::*;
#(
  parameter int SYMB_WIDTH = GF_SYMB_WIDTH,
  parameter int POLY       = GF_POLY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv_i,
  input  gf_op_e                op_i,
  input  logic [SYMB_WIDTH-1:0] a_i,
  input  logic [SYMB_WIDTH-1:0] b_i,
  output logic [SYMB_WIDTH-1:0] res_o,
  output logic                  err_o
);

  localparam int M     = SYMB_WIDTH;
  localparam int NUM   = 1 << M;
  localparam int N     = NUM - 1;
  localparam int TBL_W = NUM * M;

  typedef logic [M-1:0]   sym_t;
  typedef logic [2*M-1:0] wide_t;

  localparam sym_t N_SYM = sym_t'(N);

  function automatic logic [TBL_W-1:0] build_alog();
    logic [TBL_W-1:0] tbl;
    int x;
    tbl = '0;
    x   = 1;
    for (int e = 0; e < NUM; e++) begin
      tbl[e*M +: M] = sym_t'(x);
      x = gf_lfsr_step(x, M, POLY);
    end
    return tbl;
  endfunction

  // Slot 0 (log of zero) is left at 0; every consumer masks it in S3.
  function automatic logic [TBL_W-1:0] build_log();
    logic [TBL_W-1:0] tbl;
    int x;
    tbl = '0;
    x   = 1;
    for (int e = 0; e < N; e++) begin
      tbl[x*M +: M] = sym_t'(e);
      x = gf_lfsr_step(x, M, POLY);
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] ALOG_TBL = build_alog();
  localparam logic [TBL_W-1:0] LOG_TBL  = build_log();

  // Folding reduction: 2^m == 1 (mod 2^m-1), so hi+lo preserves the residue.
  function automatic sym_t mod_n(input wide_t v);
    logic [M:0] f1;
    sym_t       f2;
    f1 = {1'b0, v[2*M-1:M]} + {1'b0, v[M-1:0]};
    f2 = f1[M-1:0] + sym_t'(f1[M]);
    return (f2 == N_SYM) ? '0 : f2;
  endfunction

  sym_t   s1_la_q, s1_lb_q, s1_b_q;
  logic   s1_za_q, s1_zb_q;
  gf_op_e s1_op_q;

  sym_t   s2_e_q;
  logic   s2_za_q, s2_zb_q;
  gf_op_e s2_op_q;

  sym_t   s3_res_q;
  logic   s3_err_q;

  sym_t   la_d, lb_d, e_d, res_d;
  wide_t  raw_d;
  logic   err_d;

  assign la_d = LOG_TBL[int'(a_i)*M +: M];
  assign lb_d = LOG_TBL[int'(b_i)*M +: M];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    raw_d = '0;
    case (s1_op_q)
      GF_MULT: raw_d = wide_t'(s1_la_q) + wide_t'(s1_lb_q);
      GF_DIV:  raw_d = wide_t'(s1_la_q) + wide_t'(N_SYM - s1_lb_q);
      GF_INV:  raw_d = wide_t'(N_SYM - s1_la_q);
      GF_POW:  raw_d = wide_t'(s1_la_q) * wide_t'(s1_b_q);
      default: raw_d = '0;
    endcase
    e_d = mod_n(raw_d);
  end

  always_comb begin
    res_d = ALOG_TBL[int'(s2_e_q)*M +: M];
    err_d = 1'b0;
    case (s2_op_q)
      GF_MULT: if (s2_za_q || s2_zb_q) res_d = '0;
      GF_DIV: begin
        if (s2_zb_q) begin
          res_d = '0;
          err_d = 1'b1;
        end else if (s2_za_q) begin
          res_d = '0;
        end
      end
      GF_INV: begin
        if (s2_za_q) begin
          res_d = '0;
          err_d = 1'b1;
        end
      end
      GF_POW: begin
        if (s2_zb_q)      res_d = sym_t'(1);
        else if (s2_za_q) res_d = '0;
      end
      default: ;
    endcase
  end

  // NOTE: datapath registers are reset too, because the result port must read 0 out of reset;
  // all state updates use non-blocking assignments so stages shift in lockstep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_la_q  <= '0;
      s1_lb_q  <= '0;
      s1_b_q   <= '0;
      s1_za_q  <= 1'b0;
      s1_zb_q  <= 1'b0;
      s1_op_q  <= GF_MULT;
      s2_e_q   <= '0;
      s2_za_q  <= 1'b0;
      s2_zb_q  <= 1'b0;
      s2_op_q  <= GF_MULT;
      s3_res_q <= '0;
      s3_err_q <= 1'b0;
    end else if (adv_i) begin
      s1_la_q  <= la_d;
      s1_lb_q  <= lb_d;
      s1_b_q   <= b_i;
      s1_za_q  <= (a_i == '0);
      s1_zb_q  <= (b_i == '0);
      s1_op_q  <= op_i;
      s2_e_q   <= e_d;
      s2_za_q  <= s1_za_q;
      s2_zb_q  <= s1_zb_q;
      s2_op_q  <= s1_op_q;
      s3_res_q <= res_d;
      s3_err_q <= err_d;
    end
  end

  assign res_o = s3_res_q;
  assign err_o = s3_err_q;

endmodule

// File: rtl/gf_alu_pipe.sv
// Multi-lane pipelined GF(2^m) ALU with a global-stall valid/ready pipeline
// and tag passthrough; fixed 3-cycle latency.
module gf_alu_pipe
  import gf_pkg::*;
#(
  parameter int SYMB_WIDTH = GF_SYMB_WIDTH,
  parameter int POLY       = GF_POLY,
  parameter int LANES      = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*LANES-1:0]          in_op,
  input  logic [SYMB_WIDTH*LANES-1:0] in_a,
  input  logic [SYMB_WIDTH*LANES-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SYMB_WIDTH*LANES-1:0] out_res,
  output logic [LANES-1:0]            out_err,
  output logic [TAG_WIDTH-1:0]        out_tag
);

  logic                 adv;
  logic                 s1_valid_q, s2_valid_q, s3_valid_q;
  logic [TAG_WIDTH-1:0] s1_tag_q, s2_tag_q, s3_tag_q;

  // Whole pipeline moves together; bubbles are kept rather than collapsed.
  assign adv      = !s3_valid_q || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s2_tag_q   <= '0;
      s3_tag_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      s1_tag_q   <= in_tag;
      s2_tag_q   <= s1_tag_q;
      s3_tag_q   <= s2_tag_q;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gf_alu_lane #(
      .SYMB_WIDTH (SYMB_WIDTH),
      .POLY       (POLY)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .adv_i (adv),
      .op_i  (gf_op_e'(in_op[2*l +: 2])),
      .a_i   (in_a[SYMB_WIDTH*l +: SYMB_WIDTH]),
      .b_i   (in_b[SYMB_WIDTH*l +: SYMB_WIDTH]),
      .res_o (out_res[SYMB_WIDTH*l +: SYMB_WIDTH]),
      .err_o (out_err[l])
    );
  end

  assign out_valid = s3_valid_q;
  assign out_tag   = s3_tag_q;

endmodule

// File: tb/tb_gf_alu_pipe.sv
// Randomized and directed bench for gf_alu_pipe against a shift-and-xor
// field model with an in-order scoreboard.
module tb_gf_alu_pipe;

  localparam int M      = 8;
  localparam int POLY_P = 285;
  localparam int L      = 4;
  localparam int TW     = 4;
  localparam int N      = (1 << M) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [2*L-1:0]  in_op;
  logic [M*L-1:0]  in_a, in_b, out_res;
  logic [L-1:0]    out_err;
  logic [TW-1:0]   in_tag, out_tag;

  always #5 clk = ~clk;

  gf_alu_pipe #(
    .SYMB_WIDTH (M),
    .POLY       (POLY_P),
    .LANES      (L),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err),
    .out_tag   (out_tag)
  );

  typedef struct packed {
    logic [M*L-1:0] res;
    logic [L-1:0]   err;
    logic [TW-1:0]  tag;
  } beat_t;

  typedef struct packed {
    logic [2*L-1:0] op;
    logic [M*L-1:0] a;
    logic [M*L-1:0] b;
    logic [TW-1:0]  tag;
  } stim_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    stall_cycles = 0;

  // ---------------- reference model ----------------
  function automatic int gmul(input int a, input int b);
    int p = 0;
    int x = a;
    for (int i = 0; i < M; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ x;
      x = x << 1;
      if (x >= (1 << M)) x = x ^ POLY_P;
    end
    return p;
  endfunction

  function automatic int gpow(input int a, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic int ref_res(input int op, input int a, input int b);
    case (op)
      0: return gmul(a, b);
      1: return (b == 0) ? 0 : gmul(a, gpow(b, N - 1));
      2: return (a == 0) ? 0 : gpow(a, N - 1);
      default: return gpow(a, b);
    endcase
  endfunction

  function automatic bit ref_err(input int op, input int a, input int b);
    return (op == 1 && b == 0) || (op == 2 && a == 0);
  endfunction

  function automatic beat_t model_beat(input stim_t s);
    beat_t r;
    int op, a, b;
    for (int l = 0; l < L; l++) begin
      op = int'(s.op[2*l +: 2]);
      a  = int'(s.a[M*l +: M]);
      b  = int'(s.b[M*l +: M]);
      r.res[M*l +: M] = 8'(ref_res(op, a, b));
      r.err[l]        = ref_err(op, a, b);
    end
    r.tag = s.tag;
    return r;
  endfunction

  function automatic stim_t rand_stim(input int tagv);
    stim_t s;
    for (int l = 0; l < L; l++) begin
      s.op[2*l +: 2] = 2'($urandom_range(0, 3));
      s.a[M*l +: M]  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      s.b[M*l +: M]  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    end
    s.tag = 4'(tagv);
    return s;
  endfunction

  // Output monitor: records every beat taken by the sink.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready)
      got_q.push_back(beat_t'({out_res, out_err, out_tag}));
  end

  // ---------------- drivers (start and end at posedge+1) ----------------
  task automatic send(input stim_t s);
    int k = 0;
    in_valid = 1'b1;
    in_op    = s.op;
    in_a     = s.a;
    in_b     = s.b;
    in_tag   = s.tag;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_accept: in_ready=0 after %0d cycles, required 1", k);
    end else begin
      exp_q.push_back(model_beat(s));
    end
    stall_cycles += k;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!out_valid && c < 20);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (got_q.size() < exp_q.size() && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++; if (out_res !== '0) begin n_fail++; $display("FAIL reset_out_res: got %h required 0", out_res); end
    n_checks++; if (out_err !== '0) begin n_fail++; $display("FAIL reset_out_err: got %b required 0", out_err); end
    n_checks++; if (out_tag !== '0) begin n_fail++; $display("FAIL reset_out_tag: got %h required 0", out_tag); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mixed_ops();
    stim_t s;
    int    lat;
    s.op  = {2'd3, 2'd2, 2'd1, 2'd0};
    s.a   = {8'h02, 8'h02, 8'h1D, 8'h80};
    s.b   = {8'h08, 8'h00, 8'h02, 8'h02};
    s.tag = 4'hA;
    out_ready = 1'b1;
    send(s);
    wait_out(lat);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL mixed_latency: got %0d cycles required 3", lat); end
    n_checks++; if (out_res !== 32'h1D8E801D) begin n_fail++; $display("FAIL mixed_res: got %h required 1d8e801d", out_res); end
    n_checks++; if (out_err !== 4'b0000) begin n_fail++; $display("FAIL mixed_err: got %b required 0000", out_err); end
    n_checks++; if (out_tag !== 4'hA) begin n_fail++; $display("FAIL mixed_tag: got %h required a", out_tag); end
    wait_drain();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_zero_cases();
    stim_t s;
    int    lat;
    s.op  = {2'd3, 2'd0, 2'd2, 2'd1};
    s.a   = {8'h00, 8'h00, 8'h00, 8'h05};
    s.b   = {8'h00, 8'h37, 8'h00, 8'h00};
    s.tag = 4'h5;
    send(s);
    wait_out(lat);
    n_checks++; if (out_res !== 32'h01000000) begin n_fail++; $display("FAIL zero_res: got %h required 01000000", out_res); end
    n_checks++; if (out_err !== 4'b0011) begin n_fail++; $display("FAIL zero_err: got %b required 0011", out_err); end
    n_checks++; if (out_tag !== 4'h5) begin n_fail++; $display("FAIL zero_tag: got %h required 5", out_tag); end
    wait_drain();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_stream();
    beat_t e, g;
    int    idx = 0;
    out_ready    = 1'b1;
    stall_cycles = 0;
    for (int i = 0; i < 64; i++) send(rand_stim(i));
    wait_drain();
    n_checks++; if (stall_cycles != 0) begin n_fail++; $display("FAIL stream_stalls: got %0d stall cycles required 0", stall_cycles); end
    n_checks++; if (got_q.size() != 64) begin n_fail++; $display("FAIL stream_count: got %0d beats required 64", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL stream_beat%0d: got res=%h err=%b tag=%h required res=%h err=%b tag=%h",
                 idx, g.res, g.err, g.tag, e.res, e.err, e.tag);
      end
      idx++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t snap, e, g;
    bit    stable = 1'b1;
    int    idx = 0;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) send(rand_stim(i));
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          #1;
          if (c == 0) snap = beat_t'({out_res, out_err, out_tag});
          else if (beat_t'({out_res, out_err, out_tag}) !== snap) stable = 1'b0;
        end
        n_checks++; if (!stable) begin n_fail++; $display("FAIL bp_stable: outputs changed during stall, required stable %h", snap); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b required 1", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
        n_checks++;
        if (exp_q.size() - got_q.size() != 3) begin
          n_fail++;
          $display("FAIL bp_held: got %0d beats in flight required 3", exp_q.size() - got_q.size());
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    n_checks++; if (got_q.size() != 24) begin n_fail++; $display("FAIL bp_count: got %0d beats required 24", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got res=%h err=%b tag=%h required res=%h err=%b tag=%h",
                 idx, g.res, g.err, g.tag, e.res, e.err, e.tag);
      end
      idx++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_midflight();
    beat_t e, g;
    int    lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(rand_stim(i + 8));
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b required 1", out_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b required 0", out_valid); end
    n_checks++;
    if (out_res !== '0 || out_err !== '0 || out_tag !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got res=%h err=%b tag=%h required all 0", out_res, out_err, out_tag);
    end
    exp_q.delete();
    got_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall_cycles = 0;
    send(rand_stim(3));
    n_checks++; if (stall_cycles != 0) begin n_fail++; $display("FAIL rstmid_accept: got %0d wait cycles required 0", stall_cycles); end
    wait_out(lat);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL rstmid_latency: got %0d cycles required 3", lat); end
    wait_drain();
    n_checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL rstmid_count: got %0d beats required 1", got_q.size());
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL rstmid_beat: got res=%h err=%b tag=%h required res=%h err=%b tag=%h",
                 g.res, g.err, g.tag, e.res, e.err, e.tag);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_inverse_exhaustive();
    stim_t          s;
    beat_t          g;
    logic [M*L-1:0] inv_res [64];
    int             idx, av;
    out_ready = 1'b1;
    for (int j = 0; j < 64; j++) begin
      for (int l = 0; l < L; l++) begin
        idx = 4 * j + l;
        av  = (idx < N) ? idx + 1 : 1;
        s.op[2*l +: 2] = 2'd2;
        s.a[M*l +: M]  = 8'(av);
        s.b[M*l +: M]  = 8'h00;
      end
      s.tag = 4'(j);
      send(s);
    end
    wait_drain();
    n_checks++; if (got_q.size() != 64) begin n_fail++; $display("FAIL inv_count: got %0d beats required 64", got_q.size()); end
    for (int j = 0; j < 64; j++) inv_res[j] = (got_q.size() > 0) ? got_q.pop_front().res : '0;
    exp_q.delete();
    got_q.delete();
    for (int j = 0; j < 64; j++) begin
      for (int l = 0; l < L; l++) begin
        idx = 4 * j + l;
        av  = (idx < N) ? idx + 1 : 1;
        s.op[2*l +: 2] = 2'd0;
        s.a[M*l +: M]  = 8'(av);
      end
      s.b   = inv_res[j];
      s.tag = 4'(j);
      send(s);
    end
    wait_drain();
    n_checks++; if (got_q.size() != 64) begin n_fail++; $display("FAIL inv_mult_count: got %0d beats required 64", got_q.size()); end
    for (int j = 0; j < 64 && got_q.size() > 0; j++) begin
      g = got_q.pop_front();
      n_checks++;
      if (g.res !== 32'h01010101 || g.err !== 4'b0000) begin
        n_fail++;
        $display("FAIL inv_mult_beat%0d: a=%0d..%0d got res=%h err=%b required res=01010101 err=0000",
                 j, 4 * j + 1, 4 * j + 4, g.res, g.err);
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    test_reset();
    test_mixed_ops();
    test_zero_cases();
    test_stream();
    test_backpressure();
    test_reset_midflight();
    test_inverse_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit reached");
  end

endmodule
